uart_tx: RTL and testbench

// - UART transmitter: the transmit half of the UART, pairing with the receive path and its 16x oversampled baud clock.
// - Accepts one parallel word per valid/ready handshake and serialises it as start, data (LSB first), optional parity and stop bits.
// - Generates its own 1x bit-rate tick from clk; no oversampling is needed on transmit.
// - Drives the tx line of the UART top level.

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_tx_bit_timer.sv | 44 ++++
 rtl/uart_tx.sv | 158 +++++++++++++++
 tb/tb_uart_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: baud selection, baud-rate constants, divisor helper
// and the transmit FSM state encoding. Shared with the receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        BAUD_4800,
        BAUD_9600,
        BAUD_57600,
        BAUD_115200
    } baud_sel_e;

    localparam int unsigned BAUD_RATE_4800   = 4800;
    localparam int unsigned BAUD_RATE_9600   = 9600;
    localparam int unsigned BAUD_RATE_57600  = 57600;
    localparam int unsigned BAUD_RATE_115200 = 115200;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    // Floor divisor from clk to (baud * oversample); oversample = 1 on transmit.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

    // Baud rate in Hz for a selection code.
    function automatic int unsigned baud_rate(input baud_sel_e sel);
        int unsigned rate;
        case (sel)
            BAUD_4800:   rate = BAUD_RATE_4800;
            BAUD_9600:   rate = BAUD_RATE_9600;
            BAUD_57600:  rate = BAUD_RATE_57600;
            BAUD_115200: rate = BAUD_RATE_115200;
            default:     rate = BAUD_RATE_4800;
        endcase
        return rate;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// 1x bit-rate timer for the UART transmitter.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - count enable; counter is held at 0 while low
//   div       - clk cycles per bit
//   bit_tick  - high for one cycle when the count reaches div-1
module uart_tx_bit_timer #(
    parameter int unsigned DIV_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             bit_tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             last_c;

    // Count 0..div-1 and wrap; every bit therefore lasts exactly div cycles.
    always_comb begin
        cnt_d  = cnt_q;
        last_c = (cnt_q == (div - DIV_W'(1)));
        if (!en) begin
            cnt_d = '0;
        end else if (last_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    assign bit_tick = en && last_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises one word per valid/ready handshake as
// start, data (LSB first), optional parity and stop bits.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   sel_baud  - baud select, latched on handshake
//   tx_data   - word to send, sampled on handshake
//   tx_valid  - tx_data valid
//   tx_ready  - high only while idle
//   tx        - registered serial line, idles high
//   tx_busy   - high while a frame is in progress
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 10_000_000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           sel_baud,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int unsigned DIV_MAX = baud_div(CLK_FREQ, BAUD_RATE_4800, 1);
    localparam int unsigned DIV_W   = $clog2(DIV_MAX + 1);
    localparam int unsigned BCNT_W  = $clog2(DATA_BITS + 1);

    // Bit period for a baud selection code.
    function automatic logic [DIV_W-1:0] sel_div(input logic [1:0] sel);
        return DIV_W'(baud_div(CLK_FREQ, baud_rate(baud_sel_e'(sel)), 1));
    endfunction

    tx_state_e            state_q,   state_d;
    logic [DATA_BITS-1:0] shreg_q,   shreg_d;
    logic                 parity_q,  parity_d;
    logic [BCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]     div_q,     div_d;
    logic                 tx_q,      tx_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_busy_q,  tx_busy_d;
    logic                 hs_c;
    logic                 bit_tick;

    uart_tx_bit_timer #(
        .DIV_W (DIV_W)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (tx_busy_q),
        .div      (div_q),
        .bit_tick (bit_tick)
    );

    // Next state, datapath and line value; outputs are derived from the next
    // state so tx leaves idle on the handshake edge itself.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        hs_c      = tx_valid && tx_ready_q;

        case (state_q)
            TX_IDLE: begin
                if (hs_c) begin
                    state_d   = TX_START;
                    shreg_d   = tx_data;
                    parity_d  = (^tx_data) ^ (PARITY_ODD != 0);
                    div_d     = sel_div(sel_baud);
                    bit_cnt_d = '0;
                end
            end
            TX_START: begin
                if (bit_tick) begin
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == BCNT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = TX_PARITY;
                        end else begin
                            state_d = TX_STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (bit_tick) begin
                    state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                // bit_cnt is reused to count stop bits
                if (bit_tick) begin
                    if (bit_cnt_q == BCNT_W'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = TX_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        case (state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = shreg_d[0];
            TX_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase

        tx_ready_d = (state_d == TX_IDLE);
        tx_busy_d  = (state_d != TX_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            div_q      <= '0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            div_q      <= div_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q;
    assign tx_busy  = tx_busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: three instances (8N1, 8E2, 8O1) checked every cycle
// against a frame-level reference model that expands each accepted word into
// the expected per-cycle line level.
module tb_uart_tx;

    localparam int unsigned CLK_FREQ = 10_000_000;
    localparam int P_EN   [3] = '{0, 1, 1};
    localparam int P_ODD  [3] = '{0, 0, 1};
    localparam int P_STOP [3] = '{1, 2, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sel_baud;
    logic [7:0] tx_data;
    logic [2:0] tx_vld;
    logic [2:0] tx_line;
    logic [2:0] tx_rdy;
    logic [2:0] tx_bsy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int active = 0;
    int hs_cyc = 0;
    int last_fl = 0;
    bit hs_flag = 1'b0;
    bit exp_ready = 1'b1;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .sel_baud(sel_baud), .tx_data(tx_data), .tx_valid(tx_vld[0]),
        .tx_ready(tx_rdy[0]), .tx(tx_line[0]), .tx_busy(tx_bsy[0]));

    uart_tx #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_8e2 (
        .clk(clk), .rst(rst), .sel_baud(sel_baud), .tx_data(tx_data), .tx_valid(tx_vld[1]),
        .tx_ready(tx_rdy[1]), .tx(tx_line[1]), .tx_busy(tx_bsy[1]));

    uart_tx #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .sel_baud(sel_baud), .tx_data(tx_data), .tx_valid(tx_vld[2]),
        .tx_ready(tx_rdy[2]), .tx(tx_line[2]), .tx_busy(tx_bsy[2]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int baud_hz(input logic [1:0] s);
        case (s)
            2'b00:   return 4800;
            2'b01:   return 9600;
            2'b10:   return 57600;
            default: return 115200;
        endcase
    endfunction

    // Expand one word into per-cycle expected line levels.
    function automatic void push_frame(input int inst, input logic [7:0] d, input logic [1:0] s);
        int div;
        bit bits[$];
        div = int'(CLK_FREQ) / baud_hz(s);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (P_EN[inst] != 0) bits.push_back((($countones(d) % 2) == 1) ^ (P_ODD[inst] != 0));
        for (int i = 0; i < P_STOP[inst]; i++) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int j = 0; j < div; j++) exp_q.push_back(bits[i]);
        end
        last_fl = bits.size() * div;
    endfunction

    // One clock: model the handshake, then compare every instance's outputs.
    task automatic step();
        bit         hs;
        bit         e_tx;
        logic [7:0] d;
        logic [1:0] s;
        hs = tx_vld[active] && exp_ready && !rst;
        d  = tx_data;
        s  = sel_baud;
        @(posedge clk);
        cyc++;
        if (hs) begin
            push_frame(active, d, s);
            hs_cyc  = cyc;
            hs_flag = 1'b1;
        end
        #1;
        exp_ready = (exp_q.size() == 0);
        e_tx = exp_ready ? 1'b1 : exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
            if (k == active) begin
                check_eq($sformatf("tx%0d", k),    32'(tx_line[k]), 32'(e_tx));
                check_eq($sformatf("ready%0d", k), 32'(tx_rdy[k]),  32'(exp_ready));
                check_eq($sformatf("busy%0d", k),  32'(tx_bsy[k]),  32'(!exp_ready));
            end else begin
                check_eq($sformatf("idle_tx%0d", k),    32'(tx_line[k]), 32'd1);
                check_eq($sformatf("idle_ready%0d", k), 32'(tx_rdy[k]),  32'd1);
                check_eq($sformatf("idle_busy%0d", k),  32'(tx_bsy[k]),  32'd0);
            end
        end
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Present a word and hold valid until the model accepts it.
    task automatic send_word(input int inst, input logic [7:0] d, input logic [1:0] s);
        int n;
        n = 0;
        active       = inst;
        tx_data      = d;
        sel_baud     = s;
        tx_vld[inst] = 1'b1;
        hs_flag      = 1'b0;
        while (!hs_flag && n < 60000) begin
            step();
            n++;
        end
        tx_vld[inst] = 1'b0;
        tx_data      = 8'($urandom);
        if (!hs_flag) check_eq("handshake_timeout", 32'd0, 32'd1);
    endtask

    // Run until the DUT reports ready and check handshake-to-ready length.
    task automatic wait_idle(input string tag, input int exp_len);
        int n;
        n = 0;
        while (tx_rdy[active] !== 1'b1 && n < 60000) begin
            step();
            n++;
        end
        check_eq({tag, "_frame_len"}, 32'(cyc - hs_cyc), 32'(exp_len));
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("%s_tx%0d", tag, k),    32'(tx_line[k]), 32'd1);
            check_eq($sformatf("%s_ready%0d", tag, k), 32'(tx_rdy[k]),  32'd1);
            check_eq($sformatf("%s_busy%0d", tag, k),  32'(tx_bsy[k]),  32'd0);
        end
    endtask

    initial begin
        int h1;
        int inst;
        logic [7:0] d;
        logic [1:0] s;

        rst      = 1'b1;
        tx_vld   = '0;
        tx_data  = '0;
        sel_baud = 2'b00;
        #3;
        check_reset_state("rst0");
        step_n(3);
        rst = 1'b0;
        step_n(2);

        // 8N1 at 115200, 0xA5
        send_word(0, 8'hA5, 2'b11);
        check_eq("a5_start", 32'(tx_line[0]), 32'd0);
        step_n(86 + 43);
        check_eq("a5_bit0", 32'(tx_line[0]), 32'd1);
        step_n(86);
        check_eq("a5_bit1", 32'(tx_line[0]), 32'd0);
        wait_idle("a5", 860);

        // Parity at 57600: parity bit sits at bit index 9
        send_word(1, 8'h07, 2'b10);
        step_n(9 * 173 + 86);
        check_eq("par_07_even", 32'(tx_line[1]), 32'd1);
        wait_idle("par_07_even", 12 * 173);

        send_word(2, 8'h07, 2'b10);
        step_n(9 * 173 + 86);
        check_eq("par_07_odd", 32'(tx_line[2]), 32'd0);
        wait_idle("par_07_odd", 11 * 173);

        send_word(1, 8'h00, 2'b10);
        step_n(9 * 173 + 86);
        check_eq("par_00_even", 32'(tx_line[1]), 32'd0);
        wait_idle("par_00_even", 12 * 173);

        // Back-to-back with valid held: next handshake in the first ready cycle
        send_word(0, 8'h55, 2'b11);
        h1 = hs_cyc;
        send_word(0, 8'h0F, 2'b11);
        check_eq("b2b_gap", 32'(hs_cyc - h1), 32'd861);
        wait_idle("b2b", 860);

        // Baud change mid-frame only affects the next frame
        send_word(0, 8'h96, 2'b01);
        step_n(5 * 1041);
        sel_baud = 2'b11;
        wait_idle("sw_9600", 10 * 1041);
        send_word(0, 8'h69, 2'b11);
        wait_idle("sw_115200", 860);

        // Reset in the middle of the data bits
        send_word(1, 8'hC3, 2'b11);
        step_n(3 * 86 + 20);
        rst = 1'b1;
        #2;
        check_reset_state("rst_mid");
        exp_q.delete();
        exp_ready = 1'b1;
        step_n(3);
        rst = 1'b0;
        step_n(2);
        send_word(1, 8'h3C, 2'b11);
        step_n(11 * 86 + 43);
        check_eq("3c_stop2", 32'(tx_line[1]), 32'd1);
        wait_idle("3c", 12 * 86);

        // Random words, instances, fast bauds, mid-frame sel changes, back-to-back
        for (int i = 0; i < 10; i++) begin
            inst = $urandom_range(0, 2);
            d    = 8'($urandom);
            s    = 2'($urandom_range(2, 3));
            send_word(inst, d, s);
            if ($urandom_range(0, 1) == 1) begin
                step_n($urandom_range(1, 400));
                sel_baud = 2'($urandom);
            end
            if ($urandom_range(0, 1) == 1) begin
                d = 8'($urandom);
                s = 2'($urandom_range(2, 3));
                send_word(inst, d, s);
            end
            wait_idle("rnd", last_fl);
        end

        step_n(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
